bullet_ctrl: RTL and testbench

Consumes the tank controller's shoot request, position and heading, and manages a fixed pool of bullets. On each rising edge of `ShootBullet` it spawns a bullet at the tank centre with a velocity derived from the current sin/cos sample. It advances every live bullet once per frame, reflects bullets off screen edges and retires them after a fixed lifetime. Its outputs feed the bullet sprite renderer and the hit-detection logic.

---
 rtl/tank_pkg.sv | 33 +++
 rtl/bullet_slot.sv | 94 +++++++++
 rtl/bullet_ctrl.sv | 105 ++++++++++
 tb/tb_bullet_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
// Shared definitions for the tank game blocks.
//   SCREEN_X_MAX / SCREEN_Y_MAX : last visible pixel on each axis
//   trig_t                      : 8-bit sign-magnitude sin/cos sample
//                                 (bit7 = sign, 1 = negative; [6:0] magnitude,
//                                 127 = 1.0)
//   vel_t                       : signed 10-bit per-axis velocity
//   trig_to_vel(trig, speed)    : scaled velocity, (speed*mag)>>7, signed
// -----------------------------------------------------------------------------
package tank_pkg;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  typedef logic [7:0]        trig_t;
  typedef logic signed [9:0] vel_t;

  function automatic vel_t trig_to_vel(input trig_t trig, input logic [3:0] speed);
    logic [10:0] prod;
    logic [3:0]  mag;
    logic [9:0]  v;
    prod = {7'd0, speed} * {4'd0, trig[6:0]};
    mag  = prod[10:7];
    v    = {6'd0, mag};
    // Two's-complement negate; a zero magnitude stays zero either way.
    if (trig[7]) begin
      v = ~v + 10'd1;
    end
    return vel_t'(v);
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// -----------------------------------------------------------------------------
// bullet_slot
// One bullet: position, velocity, remaining life, wall handling.
// Build option: BULLET_BOUNCE_EN
//   defined   -> wall contact negates the velocity component of that axis
//   undefined -> wall contact retires the bullet (position/velocity hold)
// Ports:
//   frame_clk  in   frame clock
//   Reset      in   asynchronous active-high reset
//   i_spawn    in   load spawn values this edge (overrides motion)
//   i_x, i_y   in   spawn position
//   i_vx, i_vy in   spawn velocity
//   o_x, o_y   out  current position
//   o_active   out  slot live flag
// -----------------------------------------------------------------------------
module bullet_slot
  import tank_pkg::*;
#(
  parameter logic [9:0] LIFETIME    = 10'd300,
  parameter logic [9:0] BULLET_SIZE = 10'd3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       i_spawn,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  vel_t       i_vx,
  input  vel_t       i_vy,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_active
);

  localparam logic signed [11:0] LO_BOUND = {2'b00, BULLET_SIZE};
  localparam logic signed [11:0] HI_X     = 12'(SCREEN_X_MAX) - LO_BOUND;
  localparam logic signed [11:0] HI_Y     = 12'(SCREEN_Y_MAX) - LO_BOUND;

  logic [9:0]         r_x, r_y;
  vel_t               r_vx, r_vy;
  logic [9:0]         r_life;
  logic               r_active;
  logic signed [11:0] w_nx, w_ny;
  logic               w_hit_x, w_hit_y;

  // Widened signed sums so that underflow below 0 shows as a negative value.
  assign w_nx = $signed({2'b00, r_x}) + $signed({{2{r_vx[9]}}, r_vx});
  assign w_ny = $signed({2'b00, r_y}) + $signed({{2{r_vy[9]}}, r_vy});

  assign w_hit_x = (w_nx < LO_BOUND) || (w_nx > HI_X);
  assign w_hit_y = (w_ny < LO_BOUND) || (w_ny > HI_Y);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_vx     <= '0;
      r_vy     <= '0;
      r_life   <= '0;
      r_active <= 1'b0;
    end else if (i_spawn) begin
      r_x      <= i_x;
      r_y      <= i_y;
      r_vx     <= i_vx;
      r_vy     <= i_vy;
      r_life   <= LIFETIME;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_life <= r_life - 10'd1;
      if (r_life == 10'd1) begin
        // Last live frame: retire and freeze the position.
        r_active <= 1'b0;
      end else begin
`ifdef BULLET_BOUNCE_EN
        if (w_hit_x) r_vx <= -r_vx;
        else         r_x  <= w_nx[9:0];
        if (w_hit_y) r_vy <= -r_vy;
        else         r_y  <= w_ny[9:0];
`else
        if (w_hit_x || w_hit_y) begin
          r_active <= 1'b0;
        end else begin
          r_x <= w_nx[9:0];
          r_y <= w_ny[9:0];
        end
`endif
      end
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_active = r_active;

endmodule

// File: rtl/bullet_ctrl.sv
// -----------------------------------------------------------------------------
// bullet_ctrl
// Bullet pool manager: spawns a bullet at the tank centre on each accepted
// rising edge of ShootBullet, moves live bullets once per frame, handles walls
// and lifetime. Build option BULLET_BOUNCE_EN selects bounce vs. retire on
// wall contact (see bullet_slot).
// Ports:
//   frame_clk          in   frame clock
//   Reset              in   asynchronous active-high reset
//   ShootBullet        in   shoot request level
//   TankX, TankY       in   tank centre (pixels)
//   sin, cos           in   sign-magnitude heading samples
//   BulletX, BulletY   out  packed positions, slot i at [10i+9:10i]
//   BulletActive       out  per-slot live flags
//   Fired              out  one-frame pulse on spawn
// -----------------------------------------------------------------------------
module bullet_ctrl
  import tank_pkg::*;
#(
  parameter int         NUM_BULLETS = 4,
  parameter logic [3:0] SPEED       = 4'd6,
  parameter logic [9:0] LIFETIME    = 10'd300,
  parameter logic [5:0] COOLDOWN    = 6'd15,
  parameter logic [9:0] BULLET_SIZE = 10'd3
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic                      ShootBullet,
  input  logic [9:0]                TankX,
  input  logic [9:0]                TankY,
  input  logic [7:0]                sin,
  input  logic [7:0]                cos,
  output logic [10*NUM_BULLETS-1:0] BulletX,
  output logic [10*NUM_BULLETS-1:0] BulletY,
  output logic [NUM_BULLETS-1:0]    BulletActive,
  output logic                      Fired
);

  logic                   r_shoot_q;
  logic [5:0]             r_cooldown;
  logic                   r_fired;

  logic                   w_req;
  logic                   w_accept;
  logic [NUM_BULLETS-1:0] w_active;
  logic [NUM_BULLETS-1:0] w_free;
  logic [NUM_BULLETS-1:0] w_lowest;
  logic [NUM_BULLETS-1:0] w_spawn;
  vel_t                   w_vx, w_vy;
  logic [9:0]             w_x [NUM_BULLETS];
  logic [9:0]             w_y [NUM_BULLETS];

  assign w_req    = ShootBullet & ~r_shoot_q;
  assign w_free   = ~w_active;
  // x & -x isolates the lowest set bit: the lowest-index free slot.
  assign w_lowest = w_free & (~w_free + {{(NUM_BULLETS-1){1'b0}}, 1'b1});
  assign w_accept = w_req && (r_cooldown == 6'd0) && (|w_free);
  assign w_spawn  = w_accept ? w_lowest : '0;

  // Screen Y grows downward: flipping the sin sign bit gives vy = -sin_v.
  assign w_vx = trig_to_vel(cos, SPEED);
  assign w_vy = trig_to_vel({~sin[7], sin[6:0]}, SPEED);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_shoot_q  <= 1'b0;
      r_cooldown <= '0;
      r_fired    <= 1'b0;
    end else begin
      r_shoot_q <= ShootBullet;
      r_fired   <= w_accept;
      if (w_accept) begin
        r_cooldown <= COOLDOWN;
      end else if (r_cooldown != 6'd0) begin
        r_cooldown <= r_cooldown - 6'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
      bullet_slot #(
        .LIFETIME    (LIFETIME),
        .BULLET_SIZE (BULLET_SIZE)
      ) u_slot (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .i_spawn   (w_spawn[gi]),
        .i_x       (TankX),
        .i_y       (TankY),
        .i_vx      (w_vx),
        .i_vy      (w_vy),
        .o_x       (w_x[gi]),
        .o_y       (w_y[gi]),
        .o_active  (w_active[gi])
      );
      assign BulletX[10*gi +: 10] = w_x[gi];
      assign BulletY[10*gi +: 10] = w_y[gi];
    end
  endgenerate

  assign BulletActive = w_active;
  assign Fired        = r_fired;

endmodule

// File: tb/tb_bullet_ctrl.sv
module tb_bullet_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        ShootBullet;
  logic [9:0]  TankX, TankY;
  logic [7:0]  sin, cos;
  logic [39:0] BulletX, BulletY;
  logic [3:0]  BulletActive;
  logic        Fired;

  bullet_ctrl dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .ShootBullet  (ShootBullet),
    .TankX        (TankX),
    .TankY        (TankY),
    .sin          (sin),
    .cos          (cos),
    .BulletX      (BulletX),
    .BulletY      (BulletY),
    .BulletActive (BulletActive),
    .Fired        (Fired)
  );

  always #5 frame_clk = ~frame_clk;

  // sel: 0 Fired, 1 BulletActive, 2 X of slot, 3 Y of slot, 4 bench counter
  typedef struct {
    string tag;
    int    sel;
    int    slot;
    int    exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   obs_count;

  function automatic int observe(input int sel, input int slot);
    case (sel)
      0:       return int'(Fired);
      1:       return int'(BulletActive);
      2:       return int'(BulletX[10*slot +: 10]);
      3:       return int'(BulletY[10*slot +: 10]);
      default: return obs_count;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int slot, input int exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.slot = slot; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    int   obs;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.sel, e.slot);
      n_cmp++;
      assert (obs === e.exp) else begin
        n_mis++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
    drain();
  endtask

  task automatic do_reset();
    ShootBullet = 1'b0;
    Reset = 1'b1;
    @(posedge frame_clk);
    @(posedge frame_clk);
    #1;
    push("rst_fired", 0, 0, 0);
    push("rst_active", 1, 0, 0);
    push("rst_x0", 2, 0, 0);
    push("rst_y3", 3, 3, 0);
    drain();
    Reset = 1'b0;
    push("post_rst_active", 1, 0, 0);
    step();
  endtask

  int fires;
  int live;
  int exp_active;

  initial begin
    Reset = 1'b1; ShootBullet = 1'b0;
    TankX = '0; TankY = '0; sin = '0; cos = '0;

    // ---- 1. reset values ----
    do_reset();

    // ---- 2. straight-right shot ----
    TankX = 10'd300; TankY = 10'd250; cos = 8'h7F; sin = 8'h00;
    ShootBullet = 1'b1;
    push("r_fired", 0, 0, 1);
    push("r_active", 1, 0, 1);
    push("r_x0", 2, 0, 300);
    push("r_y0", 3, 0, 250);
    step();
    push("r_fired_drop", 0, 0, 0);
    push("r_x1", 2, 0, 305);
    step();
    push("r_x2", 2, 0, 310);
    step();
    push("r_x3", 2, 0, 315);
    push("r_y3", 3, 0, 250);
    step();

    // ---- 3. straight-up shot ----
    do_reset();
    TankX = 10'd300; TankY = 10'd250; cos = 8'h00; sin = 8'h7F;
    ShootBullet = 1'b1;
    push("u_y0", 3, 0, 250);
    step();
    push("u_y1", 3, 0, 245);
    step();
    push("u_y2", 3, 0, 240);
    push("u_x2", 2, 0, 300);
    step();

    // ---- 4a. held key: exactly one Fired ----
    do_reset();
    TankX = 10'd100; TankY = 10'd100; cos = 8'h00; sin = 8'h00;
    ShootBullet = 1'b1;
    fires = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (Fired) fires++;
    end
    ShootBullet = 1'b0;
    obs_count = fires;
    push("held_fire_count", 4, 0, 1);
    drain();

    // ---- 4b. slot exhaustion and cooldown ----
    do_reset();
    exp_active = 0;
    for (int k = 0; k < 5; k++) begin
      ShootBullet = 1'b1;
      if (k < 4) exp_active = (exp_active << 1) | 1;
      push($sformatf("exh_fired_%0d", k), 0, 0, (k < 4) ? 1 : 0);
      push($sformatf("exh_active_%0d", k), 1, 0, exp_active);
      step();
      ShootBullet = 1'b0;
      for (int j = 1; j < 20; j++) begin
        if (k == 0 && j == 5) begin
          ShootBullet = 1'b1;
          push("cooldown_ignored", 0, 0, 0);
          step();
          ShootBullet = 1'b0;
        end else begin
          step();
        end
      end
    end

    // ---- 5. wall contact ----
    do_reset();
    TankX = 10'd630; TankY = 10'd250; cos = 8'h7F; sin = 8'h00;
    ShootBullet = 1'b1;
    push("w_x0", 2, 0, 630);
    step();
    ShootBullet = 1'b0;
    push("w_x1", 2, 0, 635);
    push("w_act1", 1, 0, 1);
    step();
    push("w_x2", 2, 0, 635);
`ifdef BULLET_BOUNCE_EN
    push("w_act2", 1, 0, 1);
    step();
    push("w_x3", 2, 0, 630);
    push("w_act3", 1, 0, 1);
    step();
`else
    push("w_act2", 1, 0, 0);
    step();
    push("w_x3", 2, 0, 635);
    push("w_act3", 1, 0, 0);
    step();
`endif

    // ---- 6a. lifetime ----
    do_reset();
    TankX = 10'd200; TankY = 10'd200; cos = 8'h00; sin = 8'h00;
    ShootBullet = 1'b1;
    push("life_spawn", 1, 0, 1);
    step();
    ShootBullet = 1'b0;
    live = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (BulletActive[0]) live++;
      else break;
    end
    obs_count = live;
    push("life_frames", 4, 0, 300);
    drain();

    // ---- 6b. mid-flight asynchronous reset ----
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ShootBullet = 1'b1;
      step();
      ShootBullet = 1'b0;
      for (int j = 0; j < 16; j++) step();
    end
    push("mid_active", 1, 0, 7);
    drain();
    #2;
    Reset = 1'b1;
    #1;
    push("async_active", 1, 0, 0);
    push("async_x0", 2, 0, 0);
    drain();
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
